// File: rtl/lc3_trace_buffer.sv
// lc3_trace_buffer: captures one snapshot of the LC-3 debug outputs per
// instruction fetch into a circular trace RAM, with free-run,
// stop-on-full and triggered (pre/post) capture, plus an indexed readout.
// Optional macro TRACE_TIMESTAMP_EN prepends a 32-bit cycle counter to
// every entry (entry MSBs).
// Ports: clk/reset (sync, active-high); snoop_* core debug taps; mode/arm/
// trig_match capture control; busy/done/count/trig_index status;
// rd_req/rd_index in, rd_valid/rd_data out one cycle later.
module lc3_trace_buffer #(
  parameter int DEPTH       = 64,
  parameter int NUM_REGS    = 8,
  parameter int REG_WIDTH   = 16,
  parameter int STATE_WIDTH = 6,
  parameter int FETCH_STATE = 18,
  parameter int POST_COUNT  = 32,
`ifdef TRACE_TIMESTAMP_EN
  localparam int TS_W       = 32,
`else
  localparam int TS_W       = 0,
`endif
  localparam int ENTRY_W    = REG_WIDTH*(NUM_REGS+1) + 2*STATE_WIDTH + TS_W,
  localparam int IDX_W      = $clog2(DEPTH),
  localparam int CNT_W      = IDX_W + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [REG_WIDTH-1:0]          snoop_instruction,
  input  logic [STATE_WIDTH-1:0]        snoop_cur_state,
  input  logic [STATE_WIDTH-1:0]        snoop_next_state,
  input  logic [NUM_REGS*REG_WIDTH-1:0] snoop_regs,
  input  logic [1:0]                    mode,
  input  logic                          arm,
  input  logic [REG_WIDTH-1:0]          trig_match,
  output logic                          busy,
  output logic                          done,
  output logic [CNT_W-1:0]              count,
  output logic [IDX_W-1:0]              trig_index,
  input  logic                          rd_req,
  input  logic [IDX_W-1:0]              rd_index,
  output logic                          rd_valid,
  output logic [ENTRY_W-1:0]            rd_data
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;

  localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] POST_LAST = IDX_W'(POST_COUNT - 1);

  state_t             state, state_n, cur;
  logic               prev_match, match, fetch_evt, wr_en;
  logic [IDX_W-1:0]   wr_ptr, wr_ptr_n, base_ptr;
  logic [IDX_W-1:0]   trig_phys, trig_phys_n;
  logic [IDX_W-1:0]   post_cnt, post_cnt_n;
  logic [CNT_W-1:0]   count_r, count_n, base_cnt;
  logic [IDX_W-1:0]   oldest, rd_addr;
  logic               in_range;
  logic [ENTRY_W-1:0] snapshot;
  logic [ENTRY_W-1:0] mem [DEPTH];

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] ts;
  always_ff @(posedge clk) begin
    if (reset) ts <= '0;
    else       ts <= ts + 32'd1;
  end
  assign snapshot = {ts, snoop_regs, snoop_next_state, snoop_cur_state, snoop_instruction};
`else
  assign snapshot = {snoop_regs, snoop_next_state, snoop_cur_state, snoop_instruction};
`endif

  // Edge detect so a stalled FETCH_STATE yields a single capture.
  assign match     = (snoop_next_state == STATE_WIDTH'(FETCH_STATE));
  assign fetch_evt = match && !prev_match;

  always_comb begin
    base_ptr    = wr_ptr;
    base_cnt    = count_r;
    cur         = state;
    state_n     = state;
    post_cnt_n  = post_cnt;
    trig_phys_n = trig_phys;
    wr_en       = 1'b0;
    // arm takes priority: behave as if already ARMED with empty pointers,
    // so a coincident fetch lands in entry 0.
    if (arm) begin
      base_ptr    = '0;
      base_cnt    = '0;
      cur         = S_ARMED;
      state_n     = S_ARMED;
      post_cnt_n  = '0;
      trig_phys_n = '0;
    end
    wr_ptr_n = base_ptr;
    count_n  = base_cnt;
    if (fetch_evt && (cur == S_ARMED || cur == S_POST)) begin
      wr_en    = 1'b1;
      wr_ptr_n = base_ptr + 1'b1;
      count_n  = (base_cnt == FULL) ? FULL : base_cnt + 1'b1;
      if (cur == S_POST) begin
        post_cnt_n = post_cnt + 1'b1;
        if (post_cnt == POST_LAST) state_n = S_DONE;
      end else begin
        case (mode)
          2'd1: if (base_cnt == FULL_M1) state_n = S_DONE;
          2'd2: if (snoop_instruction == trig_match) begin
            state_n     = S_POST;
            trig_phys_n = base_ptr;
            post_cnt_n  = '0;
          end
          default: ;  // free-run (mode 3 behaves as mode 0)
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      prev_match <= 1'b0;
      wr_ptr     <= '0;
      count_r    <= '0;
      post_cnt   <= '0;
      trig_phys  <= '0;
    end else begin
      state      <= state_n;
      prev_match <= match;
      wr_ptr     <= wr_ptr_n;
      count_r    <= count_n;
      post_cnt   <= post_cnt_n;
      trig_phys  <= trig_phys_n;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[base_ptr] <= snapshot;
  end

  // Once the buffer has wrapped, the oldest entry is the next to be overwritten.
  assign oldest   = (count_r == FULL) ? wr_ptr : '0;
  assign rd_addr  = oldest + rd_index;
  assign in_range = ({1'b0, rd_index} < count_r);

  // Registered read sees the pre-write contents on a same-cycle collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= in_range ? mem[rd_addr] : '0;
    end
  end

  assign busy       = (state == S_ARMED) || (state == S_POST);
  assign done       = (state == S_DONE);
  assign count      = count_r;
  assign trig_index = trig_phys - oldest;

endmodule

// File: tb/tb_lc3_trace_buffer.sv
module tb_lc3_trace_buffer;
  localparam int DEPTH = 64, NUM_REGS = 8, REG_WIDTH = 16, STATE_WIDTH = 6;
  localparam int FETCH_STATE = 18, POST_COUNT = 32;
  localparam int IDX_W = $clog2(DEPTH), CNT_W = IDX_W + 1;
`ifdef TRACE_TIMESTAMP_EN
  localparam int TS_W = 32;
`else
  localparam int TS_W = 0;
`endif
  localparam int ENTRY_W = REG_WIDTH*(NUM_REGS+1) + 2*STATE_WIDTH + TS_W;
  typedef logic [ENTRY_W-1:0] entry_t;
  typedef logic [NUM_REGS*REG_WIDTH-1:0] regs_t;

  logic clk = 1'b0, reset = 1'b1, arm = 1'b0, rd_req = 1'b0;
  logic [REG_WIDTH-1:0] snoop_instruction = '0, trig_match = '0;
  logic [STATE_WIDTH-1:0] snoop_cur_state = '0, snoop_next_state = '0;
  regs_t snoop_regs = '0;
  logic [1:0] mode = 2'd0;
  logic [IDX_W-1:0] rd_index = '0;
  logic busy, done, rd_valid;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] trig_index;
  entry_t rd_data;

  lc3_trace_buffer #(.DEPTH(DEPTH), .NUM_REGS(NUM_REGS), .REG_WIDTH(REG_WIDTH),
    .STATE_WIDTH(STATE_WIDTH), .FETCH_STATE(FETCH_STATE), .POST_COUNT(POST_COUNT)) dut (
    .clk(clk), .reset(reset), .snoop_instruction(snoop_instruction),
    .snoop_cur_state(snoop_cur_state), .snoop_next_state(snoop_next_state),
    .snoop_regs(snoop_regs), .mode(mode), .arm(arm), .trig_match(trig_match),
    .busy(busy), .done(done), .count(count), .trig_index(trig_index),
    .rd_req(rd_req), .rd_index(rd_index), .rd_valid(rd_valid), .rd_data(rd_data));

  always #5 clk = ~clk;

  logic [31:0] tb_ts = '0;
  always @(posedge clk) tb_ts <= reset ? 32'd0 : tb_ts + 32'd1;

  // Reference model: the full history of captured snapshots since the last arm.
  entry_t hist[$];
  bit m_active = 0, m_done = 0, m_post = 0;
  int m_trig_pos = 0;
  int vectors = 0, miscompares = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input entry_t got, input entry_t exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int m_count();
    return (hist.size() > DEPTH) ? DEPTH : hist.size();
  endfunction

  function automatic int m_start();
    return (hist.size() > DEPTH) ? hist.size() - DEPTH : 0;
  endfunction

  function automatic entry_t model_read(input int idx);
    if (idx < m_count()) return hist[m_start() + idx];
    return '0;
  endfunction

  task automatic model_arm();
    hist.delete();
    m_active = 1; m_done = 0; m_post = 0; m_trig_pos = 0;
  endtask

  task automatic model_event(input entry_t e, input logic [REG_WIDTH-1:0] instr);
    int md;
    if (!m_active) return;
    md = (mode == 2'd3) ? 0 : int'(mode);
    hist.push_back(e);
    if (m_post) begin
      if (hist.size() == m_trig_pos + 1 + POST_COUNT) begin m_active = 0; m_done = 1; end
    end else if (md == 1) begin
      if (hist.size() == DEPTH) begin m_active = 0; m_done = 1; end
    end else if (md == 2 && instr == trig_match) begin
      m_post = 1; m_trig_pos = hist.size() - 1;
    end
  endtask

  function automatic logic [STATE_WIDTH-1:0] idle_state();
    logic [STATE_WIDTH-1:0] v = STATE_WIDTH'($urandom_range(0, 63));
    return (v == STATE_WIDTH'(FETCH_STATE)) ? '0 : v;
  endfunction

  function automatic regs_t rand_regs();
    regs_t r;
    for (int i = 0; i < NUM_REGS; i++) r[i*REG_WIDTH +: REG_WIDTH] = REG_WIDTH'($urandom);
    return r;
  endfunction

  function automatic logic [REG_WIDTH-1:0] instr_not(input logic [REG_WIDTH-1:0] x);
    logic [REG_WIDTH-1:0] v;
    do v = REG_WIDTH'($urandom); while (v == x);
    return v;
  endfunction

  // One fetch: nextState at FETCH_STATE for 'hold' cycles, then one idle cycle.
  // rdi >= 0 issues a read in the same cycle as the capture.
  task automatic fire(input int hold, input bit with_arm, input logic [REG_WIDTH-1:0] instr,
                      input regs_t regs, input int rdi);
    entry_t e, rexp;
    logic [STATE_WIDTH-1:0] cs = STATE_WIDTH'($urandom);
    snoop_instruction = instr; snoop_regs = regs; snoop_cur_state = cs;
    snoop_next_state = STATE_WIDTH'(FETCH_STATE);
`ifdef TRACE_TIMESTAMP_EN
    e = {tb_ts, regs, STATE_WIDTH'(FETCH_STATE), cs, instr};
`else
    e = {regs, STATE_WIDTH'(FETCH_STATE), cs, instr};
`endif
    rexp = (rdi >= 0) ? model_read(rdi) : '0;
    arm = with_arm;
    if (with_arm) model_arm();
    model_event(e, instr);
    if (rdi >= 0) begin rd_req = 1'b1; rd_index = IDX_W'(rdi); end
    step();
    arm = 1'b0;
    if (rdi >= 0) begin
      rd_req = 1'b0;
      chk("collide_vld", entry_t'(rd_valid), entry_t'(1));
      chk("collide_data", rd_data, rexp);
    end
    for (int i = 1; i < hold; i++) step();
    snoop_next_state = idle_state();
    step();
  endtask

  task automatic do_arm();
    arm = 1'b1; model_arm(); step(); arm = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int idx, output entry_t got);
    entry_t exp = model_read(idx);
    rd_req = 1'b1; rd_index = IDX_W'(idx);
    step();
    rd_req = 1'b0;
    got = rd_data;
    chk({tag, "_vld"}, entry_t'(rd_valid), entry_t'(1));
    chk(tag, rd_data, exp);
    step();
    chk({tag, "_pulse"}, entry_t'(rd_valid), entry_t'(0));
  endtask

  task automatic status(input string tag);
    chk({tag, "_count"}, entry_t'(count), entry_t'(m_count()));
    chk({tag, "_busy"}, entry_t'(busy), entry_t'(m_active));
    chk({tag, "_done"}, entry_t'(done), entry_t'(m_done));
  endtask

  initial begin
    entry_t g0, g1;
    regs_t seq_regs;
    // Reset
    repeat (3) step();
    chk("rst_busy", entry_t'(busy), entry_t'(0));
    chk("rst_done", entry_t'(done), entry_t'(0));
    chk("rst_count", entry_t'(count), entry_t'(0));
    chk("rst_trig", entry_t'(trig_index), entry_t'(0));
    chk("rst_rvld", entry_t'(rd_valid), entry_t'(0));
    chk("rst_rdata", rd_data, entry_t'(0));
    reset = 1'b0; snoop_next_state = idle_state(); step();

    // Events while IDLE are ignored
    fire(1, 0, 16'h1234, rand_regs(), -1);
    status("idle");

    // Mode 1, 10 fetches with R0..R7 = 1..8
    for (int i = 0; i < NUM_REGS; i++) seq_regs[i*REG_WIDTH +: REG_WIDTH] = REG_WIDTH'(i + 1);
    mode = 2'd1; do_arm();
    for (int i = 0; i < 10; i++) fire(1, 0, REG_WIDTH'($urandom), seq_regs, -1);
    status("m1_10");
    rd_chk("m1_idx0", 0, g0);
    rd_chk("m1_idx9", 9, g0);
    rd_chk("m1_idx_eq_count", 10, g0);

    // Mode 1, 70 fetches: stop on full
    do_arm();
    for (int i = 1; i <= 70; i++) begin
      fire(1, 0, REG_WIDTH'($urandom), rand_regs(), -1);
      if (i == 63 || i == 64 || i == 70) status("m1_full");
    end
    rd_chk("m1_idx63", 63, g0);
    rd_chk("m1_idx0b", 0, g0);

    // Mode 0, 100 fetches: wrap, then a read colliding with the overwrite
    mode = 2'd0; do_arm();
    for (int i = 0; i < 100; i++) fire(1, 0, REG_WIDTH'($urandom), rand_regs(), -1);
    status("m0_100");
    rd_chk("m0_idx0", 0, g0);
    rd_chk("m0_idx63", 63, g0);
    for (int k = 0; k < 4; k++) rd_chk("m0_rand", $urandom_range(0, DEPTH - 1), g0);
    fire(1, 0, REG_WIDTH'($urandom), rand_regs(), 0);
    rd_chk("m0_after_collide", 0, g0);

    // Mode 2, trigger on 0xF025 at event 50 (restart from ARMED)
    mode = 2'd2; trig_match = 16'hF025; do_arm();
    for (int i = 1; i <= 100; i++) begin
      fire(1, 0, (i == 50) ? 16'hF025 : instr_not(16'hF025), rand_regs(), -1);
      if (i == 81 || i == 82 || i == 100) status("m2");
    end
    chk("m2_trig_index", entry_t'(trig_index), entry_t'(m_trig_pos - m_start()));
    rd_chk("m2_trig_entry", m_trig_pos - m_start(), g0);
    chk("m2_trig_instr", entry_t'(g0[REG_WIDTH-1:0]), entry_t'(16'hF025));
    rd_chk("m2_idx63", 63, g0);

    // Stall on FETCH_STATE gives one entry; arm coincident with a fetch
    mode = 2'd0; do_arm();
    fire(5, 0, REG_WIDTH'($urandom), rand_regs(), -1);
    status("stall");
    fire(1, 1, REG_WIDTH'($urandom), rand_regs(), -1);
    status("arm_coinc");
    rd_chk("arm_coinc_idx0", 0, g0);

    // Reserved mode behaves as free-run
    mode = 2'd3; do_arm();
    for (int i = 0; i < 3; i++) fire(1, 0, REG_WIDTH'($urandom), rand_regs(), -1);
    status("m3");

`ifdef TRACE_TIMESTAMP_EN
    // Timestamps: captures at cycles 12 and 40 after reset
    reset = 1'b1; hist.delete(); m_active = 0; m_done = 0; m_post = 0;
    step(); reset = 1'b0; mode = 2'd0;
    do_arm();
    while (tb_ts < 12) step();
    fire(1, 0, REG_WIDTH'($urandom), rand_regs(), -1);
    while (tb_ts < 40) step();
    fire(1, 0, REG_WIDTH'($urandom), rand_regs(), -1);
    rd_chk("ts_e0", 0, g0);
    rd_chk("ts_e1", 1, g1);
    chk("ts_delta", entry_t'(g1[ENTRY_W-1 -: 32] - g0[ENTRY_W-1 -: 32]), entry_t'(28));
    rd_chk("ts_idx_eq_count", 2, g0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
